// File: rtl/div_pipeline.sv
// ============================================================================
// div_pipeline : pipelined RV32M divider (DIV/DIVU/REM/REMU), restoring
//                division on magnitudes, STAGES register stages.
// Optional macro DIV_OUT_REG_EN adds an output register (latency STAGES+1).
// Revision 1.0
// ============================================================================
`default_nettype none

module div_pipeline #(
    parameter int XLEN   = 32,
    parameter int STAGES = 8     // XLEN must be a multiple of STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            div_valid,
    output logic            div_get_rem,
    output logic [4:0]      div_dst,
    output logic [XLEN-1:0] div_quotient,
    output logic [XLEN-1:0] div_remainder,
    output logic            div_wb_soon,
    output logic [31:0]     busy_mask
);

    localparam int c_STEPS = XLEN / STAGES;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            get_rem;
        logic            neg_q;
        logic            neg_r;
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] q;     // dividend bits shift out as quotient bits shift in
        logic [XLEN-1:0] dvs;
    } stage_t;

    function automatic stage_t f_chunk(input stage_t s);
        stage_t        o;
        logic [XLEN:0] w_diff;
        logic          w_msb;
        o = s;
        for (int i = 0; i < c_STEPS; i++) begin
            w_msb  = o.q[XLEN-1];
            w_diff = {o.rem, w_msb} - {1'b0, o.dvs};
            o.q    = {o.q[XLEN-2:0], ~w_diff[XLEN]};
            o.rem  = w_diff[XLEN] ? {o.rem[XLEN-2:0], w_msb} : w_diff[XLEN-1:0];
        end
        return o;
    endfunction

    stage_t r_stage [STAGES];
    stage_t w_issue;
    stage_t w_last;
    logic   w_signed;
    logic   [XLEN-1:0] w_quot;
    logic   [XLEN-1:0] w_rem;
    logic   [31:0]     w_busy;

    // Only the M-extension divide encodings (funct3[2]=1) launch a writeback.
    always_comb begin
        w_signed        = ~i_funct3[0];
        w_issue         = '0;
        w_issue.valid   = i_valid && i_funct3[2] && (i_rd != 5'd0);
        w_issue.rd      = i_rd;
        w_issue.get_rem = i_funct3[1];
        w_issue.neg_q   = w_signed && (i_dividend[XLEN-1] ^ i_divisor[XLEN-1])
                          && (i_divisor != '0);
        w_issue.neg_r   = w_signed && i_dividend[XLEN-1];
        w_issue.q       = (w_signed && i_dividend[XLEN-1]) ? -i_dividend : i_dividend;
        w_issue.dvs     = (w_signed && i_divisor[XLEN-1])  ? -i_divisor  : i_divisor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= f_chunk(w_issue);
            for (int k = 1; k < STAGES; k++) r_stage[k] <= f_chunk(r_stage[k-1]);
        end
    end

    always_comb begin
        w_last = r_stage[STAGES-1];
        w_quot = w_last.neg_q ? -w_last.q   : w_last.q;
        w_rem  = w_last.neg_r ? -w_last.rem : w_last.rem;
        w_busy = '0;
        for (int k = 0; k < STAGES; k++)
            if (r_stage[k].valid) w_busy[r_stage[k].rd] = 1'b1;
    end

`ifdef DIV_OUT_REG_EN
    logic            r_out_valid;
    logic            r_out_get_rem;
    logic [4:0]      r_out_dst;
    logic [XLEN-1:0] r_out_quot;
    logic [XLEN-1:0] r_out_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_get_rem <= 1'b0;
            r_out_dst     <= '0;
            r_out_quot    <= '0;
            r_out_rem     <= '0;
        end else begin
            r_out_valid   <= w_last.valid;
            r_out_get_rem <= w_last.get_rem;
            r_out_dst     <= w_last.rd;
            r_out_quot    <= w_quot;
            r_out_rem     <= w_rem;
        end
    end

    assign div_valid     = r_out_valid;
    assign div_get_rem   = r_out_get_rem;
    assign div_dst       = r_out_dst;
    assign div_quotient  = r_out_quot;
    assign div_remainder = r_out_rem;
    assign div_wb_soon   = w_last.valid;
    assign busy_mask     = w_busy | (r_out_valid ? (32'd1 << r_out_dst) : 32'd0);
`else
    logic w_pre_last_valid;

    if (STAGES > 1) begin : g_soon_pipe
        assign w_pre_last_valid = r_stage[STAGES-2].valid;
    end else begin : g_soon_issue
        assign w_pre_last_valid = w_issue.valid;
    end

    assign div_valid     = w_last.valid;
    assign div_get_rem   = w_last.get_rem;
    assign div_dst       = w_last.rd;
    assign div_quotient  = w_quot;
    assign div_remainder = w_rem;
    assign div_wb_soon   = w_pre_last_valid;
    assign busy_mask     = w_busy;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_pipeline.sv
// ============================================================================
// tb_div_pipeline : scoreboard bench for div_pipeline with directed vectors.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_div_pipeline;

    localparam int XLEN = 32;
`ifdef DIV_OUT_REG_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic        get_rem;
        logic [31:0] q;
        logic [31:0] r;
        int          issue;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_funct3 = 3'b100;
    logic [4:0]  i_rd = 5'd0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        div_valid, div_get_rem, div_wb_soon;
    logic [4:0]  div_dst;
    logic [31:0] div_quotient, div_remainder, busy_mask;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    div_pipeline #(.XLEN(XLEN), .STAGES(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_funct3(i_funct3),
        .i_rd(i_rd), .i_dividend(i_dividend), .i_divisor(i_divisor),
        .div_valid(div_valid), .div_get_rem(div_get_rem), .div_dst(div_dst),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_wb_soon(div_wb_soon), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, req);
        end
    endtask

    // Monitor: expected busy/wb_soon derived from the scoreboard contents.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] eb;
            logic        es;
            eb = '0;
            es = 1'b0;
            foreach (sb[i]) begin
                if (cyc > sb[i].issue) eb[sb[i].rd] = 1'b1;
                if (sb[i].due == cyc + 1) es = 1'b1;
            end
            chk("busy_mask", busy_mask, eb);
            chk("wb_soon", {31'd0, div_wb_soon}, {31'd0, es});
            if (div_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, div_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_cycle", cyc, e.due);
                    chk("div_dst", {27'd0, div_dst}, {27'd0, e.rd});
                    chk("div_get_rem", {31'd0, div_get_rem}, {31'd0, e.get_rem});
                    chk("div_quotient", div_quotient, e.q);
                    chk("div_remainder", div_remainder, e.r);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_valid", {31'd0, div_valid}, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid    = 1'b1;
        i_funct3   = f3;
        i_rd       = rd;
        i_dividend = a;
        i_divisor  = b;
        if (rd != 5'd0) begin
            e.rd = rd; e.get_rem = f3[1]; e.q = eq; e.r = er;
            e.issue = cyc; e.due = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        idle(3);
        @(negedge clk);
        chk("rst_div_valid", {31'd0, div_valid}, 32'd0);
        chk("rst_wb_soon", {31'd0, div_wb_soon}, 32'd0);
        chk("rst_busy_mask", busy_mask, 32'd0);
        chk("rst_quotient", div_quotient, 32'd0);
        chk("rst_remainder", div_remainder, 32'd0);
        chk("rst_dst", {27'd0, div_dst}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic and signed cases
        issue(3'b101, 5'd5, 32'd100, 32'd7, 32'd14, 32'd2);
        idle(10);
        issue(3'b100, 5'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        issue(3'b110, 5'd7, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        issue(3'b100, 5'd9, 32'hFFFFFFEC, 32'hFFFFFFFA, 32'd3, 32'hFFFFFFFE);
        issue(3'b101, 5'd10, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'd15);
        // Divide by zero
        issue(3'b100, 5'd11, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
        issue(3'b110, 5'd12, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
        issue(3'b101, 5'd13, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7);
        // Signed overflow
        issue(3'b100, 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        issue(3'b110, 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        idle(12);

        // Eight back-to-back DIVU plus an rd=0 op
        issue(3'b101, 5'd1, 32'd100, 32'd7, 32'd14, 32'd2);
        issue(3'b101, 5'd2, 32'd200, 32'd7, 32'd28, 32'd4);
        issue(3'b101, 5'd3, 32'd300, 32'd7, 32'd42, 32'd6);
        issue(3'b101, 5'd4, 32'd400, 32'd7, 32'd57, 32'd1);
        issue(3'b101, 5'd5, 32'd500, 32'd7, 32'd71, 32'd3);
        issue(3'b101, 5'd6, 32'd600, 32'd7, 32'd85, 32'd5);
        issue(3'b101, 5'd7, 32'd700, 32'd7, 32'd100, 32'd0);
        issue(3'b101, 5'd8, 32'd800, 32'd7, 32'd114, 32'd2);
        issue(3'b101, 5'd0, 32'd900, 32'd7, 32'd128, 32'd4);
        @(negedge clk);
`ifndef DIV_OUT_REG_EN
        chk("busy_batch", busy_mask, 32'h000001FE);
`else
        chk("busy_batch", busy_mask, 32'h000001FE);
`endif
        idle(14);

        // Reset mid-flight
        issue(3'b101, 5'd3, 32'd50, 32'd5, 32'd10, 32'd0);
        idle(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("flush_busy", busy_mask, 32'd0);
        idle(12);

        // Drain bound
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_pipeline.md
# div_pipeline

Pipelined RISC-V M-extension divider for DIV, DIVU, REM and REMU.
- Ops are accepted from the execute stage at up to one per cycle.
- Each op runs through STAGES register stages that retire XLEN/STAGES quotient bits per stage (restoring division on magnitudes).
- Result is delivered on the divider result port of the writeback stage (div_valid/div_get_rem/div_dst/div_quotient/div_remainder); writeback gives it priority over the main pipeline write.
- Also exports a destination busy mask for decode hazard stalls, and a one-cycle-early warning so the main pipeline can free the writeback slot.

## Interface
Parameters:
- XLEN, 32, operand width.
- STAGES, 8, pipeline depth; XLEN % STAGES == 0 required.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  divide op issued this cycle.
- i_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rd  in  5  destination register.
- i_dividend  in  XLEN  rs1 value.
- i_divisor  in  XLEN  rs2 value.
- div_valid  out  1  result valid this cycle.
- div_get_rem  out  1  1 = write remainder, 0 = quotient.
- div_dst  out  5  destination register.
- div_quotient  out  XLEN  final signed/unsigned quotient.
- div_remainder  out  XLEN  final remainder.
- div_wb_soon  out  1  div_valid will be high next cycle.
- busy_mask  out  32  bit r set while an op targeting xr is in flight.

## Operation
- Accept: no ready signal; every i_valid cycle is accepted. Ops with i_rd == 0 are computed but never raise div_valid and never set busy_mask.
- Issue fixup, funct3[0]==0 (signed): take magnitudes of both operands and record two flags.
  - neg_q = sign(dividend) XOR sign(divisor), forced 0 when divisor == 0.
  - neg_r = sign(dividend).
  - Unsigned ops: neg_q = neg_r = 0.
- Each stage performs XLEN/STAGES restoring steps: shift remainder left, bring in the next dividend MSB, subtract the divisor if no borrow, set the quotient bit.
- Each stage carries: remainder, shifting dividend/quotient, divisor magnitude, neg_q, neg_r, get_rem (= funct3[1]), rd, and a valid bit.
- Final fixup (combinational on the last stage): negate quotient if neg_q; negate remainder if neg_r.
- Divide by zero: quotient = all ones, remainder = original dividend (signed or unsigned). This falls out of restoring division plus the neg_q suppression.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No special case is needed; it is produced naturally.
- busy_mask: OR over all valid stages of (1 << rd). Multiple in-flight ops to the same rd are allowed.
- div_dst, div_get_rem, div_quotient and div_remainder are don't-care when div_valid is 0, but must not contain X after reset.

## Timing
- Op accepted at the edge ending cycle t → div_valid high exactly in cycle t+STAGES (t+8 by default), for one cycle.
- Throughput: one op per cycle. Back-to-back ops retire on consecutive cycles in issue order.
- div_wb_soon high in cycle t+STAGES−1.
- busy_mask bit set in cycles t+1 through t+STAGES inclusive, clear at t+STAGES+1. In cycle t the hazard is covered by execute forwarding/stall logic.
- Reset (rst_n low at an edge) clears every stage valid bit. In the following cycle: div_valid, div_wb_soon and busy_mask are all 0. Data registers reset to 0, so all outputs read 0.
- Reset mid-flight discards all in-flight ops; none ever appear.
- An i_valid in the same cycle as rst_n low is dropped.

## Configuration
- DIV_OUT_REG_EN defined:
  - Fixup results and control are registered once more.
  - Latency becomes STAGES+1 (9).
  - div_wb_soon fires at t+STAGES.
  - busy_mask also covers the output register, so bits clear at t+STAGES+2.
- DIV_OUT_REG_EN undefined: outputs are combinational off the last stage, with the latency given above.

## Test plan
- DIVU 100/7, rd=5, issued cycle 0 → cycle 8: div_valid=1, div_dst=5, div_get_rem=0, div_quotient=14, div_remainder=2; div_wb_soon=1 in cycle 7 only.
- DIV −7/2, then REM −7/2 in the next cycle → cycle 8: quotient 0xFFFFFFFD; cycle 9: div_get_rem=1, remainder 0xFFFFFFFF.
- DIV 0x12345678/0 → quotient 0xFFFFFFFF. REM −5/0 → remainder 0xFFFFFFFB. DIVU 7/0 → quotient 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000. REM of the same operands → 0.
- Eight back-to-back DIVU ops, rd=1..8, cycles 0–7, plus rd=0 in cycle 8:
  - busy_mask = 0x000001FE in cycle 8.
  - Results appear in cycles 8–15 in order.
  - No div_valid in cycle 16.
  - busy_mask = 0 in cycle 16.
- Issue rd=3 in cycle 0, drive rst_n low in cycle 4 → busy_mask=0 and div_valid=0 from cycle 5 onward; no result in cycle 8.
